// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder-buffer control slice.
// The typedefs describe the default 32-entry configuration.
package rob_pkg;

    localparam int unsigned rob_depth    = 32;
    localparam int unsigned rob_ptrwidth = $clog2(rob_depth);

    typedef logic [rob_ptrwidth-1:0] rob_ptr_t;
    typedef logic [rob_ptrwidth:0]   rob_cnt_t;

    // True when tag lies in the live window [head, head+count) modulo depth.
    function automatic logic in_window(int unsigned tag, int unsigned head,
                                       int unsigned count, int unsigned depth);
        return ((tag - head) & (depth - 1)) < count;
    endfunction

endpackage

// File: rtl/rob_wrap_counter.sv
// Free-running pointer that wraps at 2**p_width, with synchronous clear.
module rob_WrapCounter #(
    parameter int p_width = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    output logic [p_width-1:0] q
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + p_width'(1);
        end
    end

endmodule

// File: rtl/rob_ctrl.sv
// In-order allocate / out-of-order writeback / in-order retire control for the
// ROB register array. Owns head, tail and live count; the datapath owns data and occ.
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int p_depth    = 32,
    parameter int p_ptrwidth = $clog2(p_depth),
    parameter int p_bitwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_val,
    output logic                  alloc_rdy,
    output logic [p_ptrwidth-1:0] alloc_tag,
    input  logic                  wb_val,
    input  logic [p_ptrwidth-1:0] wb_tag,
    input  logic [p_bitwidth-1:0] wb_data,
    output logic                  wb_err,
    output logic                  commit_val,
    input  logic                  commit_rdy,
    output logic [p_ptrwidth-1:0] commit_tag,
    output logic [p_bitwidth-1:0] commit_data,
    output logic [p_ptrwidth:0]   count,
    output logic [p_depth-1:0]    wr_data,
    output logic [p_bitwidth-1:0] wr_data_in,
    input  logic [p_bitwidth-1:0] data_out [p_depth],
    output logic [p_depth-1:0]    clr_occ,
    input  logic [p_depth-1:0]    occ
);

    typedef logic [p_ptrwidth-1:0] ptr_t;
    typedef logic [p_ptrwidth:0]   cnt_t;

    ptr_t head;
    ptr_t tail;
    logic alloc_fire;
    logic commit_fire;
    logic wb_ok;

    // Full is judged on the registered count only; a same-cycle retire never frees a slot early.
    assign alloc_rdy   = !flush && (count != cnt_t'(p_depth));
    assign alloc_fire  = alloc_val && alloc_rdy;
    assign alloc_tag   = tail;

    assign commit_val  = !flush && (count != '0) && occ[head];
    assign commit_fire = commit_val && commit_rdy;
    assign commit_tag  = head;
    assign commit_data = data_out[head];

    assign wb_ok      = wb_val && !flush && !occ[wb_tag]
                      && in_window(32'(wb_tag), 32'(head), 32'(count), p_depth);
    assign wb_err     = wb_val && !flush && !wb_ok;
    assign wr_data_in = wb_data;

    // NOTE: defaults first so no path through this block leaves a strobe unassigned (no latch).
    always_comb begin
        wr_data = '0;
        clr_occ = '0;
        if (wb_ok) begin
            wr_data[wb_tag] = 1'b1;
        end
        if (flush) begin
            clr_occ = '1;
        end else if (commit_fire) begin
            clr_occ[head] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (alloc_fire && !commit_fire) begin
            count <= count + cnt_t'(1);
        end else if (commit_fire && !alloc_fire) begin
            count <= count - cnt_t'(1);
        end
    end

    rob_WrapCounter #(.p_width(p_ptrwidth)) u_head (
        .clk (clk),
        .rst (rst),
        .en  (commit_fire),
        .clr (flush),
        .q   (head)
    );

    rob_WrapCounter #(.p_width(p_ptrwidth)) u_tail (
        .clk (clk),
        .rst (rst),
        .en  (alloc_fire),
        .clr (flush),
        .q   (tail)
    );

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl paired with a behavioural datapath (4 entries, 8-bit payload);
// a queue model of the ROB predicts every output each cycle.
module tb_rob_ctrl;

    localparam int DEPTH = 4;
    localparam int PW    = 2;
    localparam int BW    = 8;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            flush      = 1'b0;
    logic            alloc_val  = 1'b0;
    logic            wb_val     = 1'b0;
    logic [PW-1:0]   wb_tag     = '0;
    logic [BW-1:0]   wb_data    = '0;
    logic            commit_rdy = 1'b0;

    logic            alloc_rdy;
    logic [PW-1:0]   alloc_tag;
    logic            wb_err;
    logic            commit_val;
    logic [PW-1:0]   commit_tag;
    logic [BW-1:0]   commit_data;
    logic [PW:0]     count;
    logic [DEPTH-1:0] wr_data;
    logic [BW-1:0]   wr_data_in;
    logic [DEPTH-1:0] clr_occ;
    logic [DEPTH-1:0] occ;
    logic [BW-1:0]   dp_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rob_ctrl #(.p_depth(DEPTH), .p_ptrwidth(PW), .p_bitwidth(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_val   (alloc_val),
        .alloc_rdy   (alloc_rdy),
        .alloc_tag   (alloc_tag),
        .wb_val      (wb_val),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .wb_err      (wb_err),
        .commit_val  (commit_val),
        .commit_rdy  (commit_rdy),
        .commit_tag  (commit_tag),
        .commit_data (commit_data),
        .count       (count),
        .wr_data     (wr_data),
        .wr_data_in  (wr_data_in),
        .data_out    (dp_mem),
        .clr_occ     (clr_occ),
        .occ         (occ)
    );

    // Behavioural datapath: payload array plus occupancy bits.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_occ[i]) begin
                    occ[i] <= 1'b0;
                end else if (wr_data[i]) begin
                    occ[i]    <= 1'b1;
                    dp_mem[i] <= wr_data_in;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: an in-order list of live entries, each remembering whether it completed.
    typedef struct {
        int          tag;
        bit          done;
        logic [BW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   next_tag = 0;

    function automatic int find_tag(input int tag);
        foreach (mq[i]) if (mq[i].tag == tag) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            mq.delete();
            next_tag = 0;
        end else begin
            bit   c_fire;
            bit   a_fire;
            int   idx;
            ent_t e;
            c_fire = (mq.size() > 0) && mq[0].done && commit_rdy;
            a_fire = alloc_val && (mq.size() < DEPTH);
            idx    = find_tag(int'(wb_tag));
            if (wb_val && idx >= 0) begin
                e = mq[idx];
                if (!e.done) begin
                    e.done  = 1'b1;
                    e.data  = wb_data;
                    mq[idx] = e;
                end
            end
            if (c_fire) void'(mq.pop_front());
            if (a_fire) begin
                mq.push_back('{tag: next_tag, done: 1'b0, data: '0});
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            int   sz;
            int   idx;
            bit   e_wb_ok;
            bit   e_cval;
            int   e_ctag;
            logic [DEPTH-1:0] e_wr;
            logic [DEPTH-1:0] e_clr;
            sz      = mq.size();
            idx     = find_tag(int'(wb_tag));
            e_wb_ok = 1'b0;
            if (wb_val && !flush && idx >= 0) e_wb_ok = !mq[idx].done;
            e_wr    = e_wb_ok ? DEPTH'(1) << wb_tag : '0;
            e_cval  = 1'b0;
            if (!flush && sz > 0) e_cval = mq[0].done;
            e_ctag  = (sz > 0) ? mq[0].tag : next_tag;
            e_clr   = '0;
            if (flush) e_clr = '1;
            else if (e_cval && commit_rdy) e_clr = DEPTH'(1) << e_ctag;

            check("m_alloc_rdy",  32'(alloc_rdy),  32'(!flush && sz < DEPTH));
            check("m_alloc_tag",  32'(alloc_tag),  32'(next_tag));
            check("m_count",      32'(count),      32'(sz));
            check("m_wr_data",    32'(wr_data),    32'(e_wr));
            check("m_wb_err",     32'(wb_err),     32'(wb_val && !flush && !e_wb_ok));
            check("m_wr_data_in", 32'(wr_data_in), 32'(wb_data));
            check("m_commit_val", 32'(commit_val), 32'(e_cval));
            check("m_commit_tag", 32'(commit_tag), 32'(e_ctag));
            check("m_clr_occ",    32'(clr_occ),    32'(e_clr));
            if (e_cval) check("m_commit_data", 32'(commit_data), 32'(mq[0].data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; alloc_val = 1'b0; wb_val = 1'b0; commit_rdy = 1'b0;
        wb_tag = '0; wb_data = '0;
    endtask

    initial begin
        // Reset values
        tick();
        check("rst_alloc_rdy",  32'(alloc_rdy),  32'd1);
        check("rst_commit_val", 32'(commit_val), 32'd0);
        check("rst_count",      32'(count),      32'd0);
        check("rst_alloc_tag",  32'(alloc_tag),  32'd0);
        check("rst_strobes",    32'({wr_data, clr_occ}), 32'd0);
        rst = 1'b0;
        tick();

        // Fill: tags 0..3 in order, then full; extra request ignored
        alloc_val = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("fill_tag", 32'(alloc_tag), 32'(i));
            tick();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_rdy",   32'(alloc_rdy), 32'd0);
        check("full_tail_wrap", 32'(alloc_tag), 32'd0);
        tick();
        check("full_ignored", 32'(count), 32'd4);
        alloc_val = 1'b0;

        // Out-of-order writebacks: tag 2 first, then tag 0
        wb_val = 1'b1; wb_tag = 2'd2; wb_data = 8'h22;
        #1;
        check("wb2_strobe", 32'(wr_data), 32'b0100);
        check("wb2_err",    32'(wb_err),  32'd0);
        tick();
        wb_tag = 2'd0; wb_data = 8'h00;
        #1;
        check("wb0_no_commit_yet", 32'(commit_val), 32'd0);
        tick();
        wb_val = 1'b0;
        #1;
        check("head_ready",  32'(commit_val),  32'd1);
        check("head_data",   32'(commit_data), 32'h00);
        commit_rdy = 1'b1;
        #1;
        check("commit0_clr", 32'(clr_occ), 32'b0001);
        tick();
        check("blocked_tag1", 32'(commit_val), 32'd0);
        check("after_commit_count", 32'(count), 32'd3);
        tick();
        check("still_blocked", 32'(commit_val), 32'd0);

        // Rejections: tag outside window, duplicate on occupied, tag allocated this cycle
        wb_val = 1'b1; wb_tag = 2'd0; wb_data = 8'h99;
        #1;
        check("oow_err",    32'(wb_err),  32'd1);
        check("oow_strobe", 32'(wr_data), 32'd0);
        wb_tag = 2'd2;
        #1;
        check("dup_err",    32'(wb_err),  32'd1);
        check("dup_strobe", 32'(wr_data), 32'd0);
        alloc_val = 1'b1; wb_tag = 2'd0;
        #1;
        check("same_cycle_alloc_err", 32'(wb_err), 32'd1);
        tick();

        // Full + commit + alloc in the same cycle: no alloc bypass
        wb_tag = 2'd1; wb_data = 8'h11;
        #1;
        check("wb1_strobe", 32'(wr_data), 32'b0010);
        tick();
        wb_val = 1'b0;
        #1;
        check("fullc_rdy",   32'(alloc_rdy),   32'd0);
        check("fullc_data",  32'(commit_data), 32'h11);
        check("fullc_clr",   32'(clr_occ),     32'b0010);
        tick();
        check("post_count",  32'(count),       32'd3);
        check("post_tag",    32'(alloc_tag),   32'd1);
        check("post_data",   32'(commit_data), 32'h22);
        tick();
        check("both_count",  32'(count),       32'd3);
        check("both_head",   32'(commit_tag),  32'd3);
        alloc_val = 1'b0; commit_rdy = 1'b0;

        // Flush with three live entries dominates every handshake
        flush = 1'b1; alloc_val = 1'b1; commit_rdy = 1'b1;
        wb_val = 1'b1; wb_tag = 2'd3; wb_data = 8'h33;
        #1;
        check("flush_clr",   32'(clr_occ),    32'b1111);
        check("flush_rdy",   32'(alloc_rdy),  32'd0);
        check("flush_cval",  32'(commit_val), 32'd0);
        check("flush_werr",  32'(wb_err),     32'd0);
        check("flush_wr",    32'(wr_data),    32'd0);
        tick();
        idle();
        #1;
        check("postflush_count", 32'(count),      32'd0);
        check("postflush_tail",  32'(alloc_tag),  32'd0);
        check("postflush_head",  32'(commit_tag), 32'd0);

        // Asynchronous reset in mid-operation
        alloc_val = 1'b1;
        tick();
        tick();
        alloc_val = 1'b0;
        #1;
        check("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count),     32'd0);
        check("async_rst_tail",  32'(alloc_tag), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Mixed traffic checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            alloc_val  = 1'($urandom_range(0, 1));
            wb_val     = 1'($urandom_range(0, 1));
            wb_tag     = PW'($urandom_range(0, DEPTH - 1));
            wb_data    = BW'($urandom);
            commit_rdy = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
